fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of producers sharing one FIFO write port (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: data width, equal to the downstream FIFO width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4: maximum consecutive beats per grant when bursting is enabled (1..16).
REQ-004 The block SHALL have clk  input  1: clock; all state updates on its rising edge.
REQ-005 The block SHALL have rst  input  1: reset, synchronous, active-high.
REQ-006 The block SHALL have req_valid  input  NUM_REQ: bit i set means producer i presents a beat.
REQ-007 The block SHALL have req_data  input  NUM_REQ*DATA_WIDTH: producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have req_ready  output  NUM_REQ: one-hot or zero; bit i set means producer i's beat is accepted this cycle.
REQ-009 The block SHALL have fifo_wr_en  output  1: write strobe to the FIFO.
REQ-010 The block SHALL have fifo_din  output  DATA_WIDTH: write data to the FIFO.
REQ-011 The block SHALL have fifo_full  input  1: FIFO full flag.
REQ-012 The block SHALL have grant_id  output  $clog2(NUM_REQ): index of the requester written this cycle; 0 when fifo_wr_en=0.

Function
REQ-013 A beat SHALL transfer in a cycle iff fifo_wr_en=1, which SHALL equal (|req_valid) & !fifo_full & !rst.
REQ-014 Outputs req_ready, fifo_wr_en, fifo_din and grant_id SHALL be combinational from state and inputs: zero-cycle latency, no buffering.
REQ-015 The winner SHALL be chosen round-robin: first asserted req_valid searching upward from (last_grant+1) mod NUM_REQ, wrapping.
REQ-016 req_ready[winner] SHALL equal fifo_wr_en; all other req_ready bits SHALL be 0.
REQ-017 fifo_din SHALL equal the winner's req_data slice when fifo_wr_en=1, and 0 otherwise.
REQ-018 On each transfer, last_grant SHALL update to the winner at the clock edge; with no transfer, last_grant SHALL hold.
REQ-019 When fifo_full=1, no transfer SHALL occur and all state (last_grant, burst state) SHALL hold; the same winner SHALL be chosen when full deasserts if inputs are unchanged.
REQ-020 A producer SHALL hold req_valid and req_data stable until it sees req_ready; the arbiter SHALL not depend on req_valid deassertion for correctness.

Reset
REQ-021 While rst=1: req_ready=0, fifo_wr_en=0, fifo_din=0, grant_id=0.
REQ-022 At a reset edge, last_grant SHALL become NUM_REQ-1 (producer 0 wins first), burst_cnt 0, lock 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; no transfer SHALL occur in the reset cycle.

Configuration
REQ-024 With macro FIFO_ARB_BURST_EN defined, a winner SHALL become locked: the grant SHALL stay with it while its req_valid=1 and fewer than BURST_LEN beats have transferred.
REQ-025 With FIFO_ARB_BURST_EN defined, burst_cnt SHALL count transferred beats of the locked requester; the lock SHALL release after beat BURST_LEN or on the first cycle its req_valid=0, and round-robin SHALL resume from that requester+1.
REQ-026 With FIFO_ARB_BURST_EN defined, a full stall SHALL neither count nor release the lock.
REQ-027 Without FIFO_ARB_BURST_EN, burst logic SHALL be absent and the grant SHALL rotate after every beat (equivalent to BURST_LEN=1).

Verification
REQ-028 The bench SHALL cover: after reset, req_valid=4'b1111 continuously with fifo_full=0 and no burst macro -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-029 The bench SHALL cover: req_valid=4'b0101 only -> grants alternate 0,2,0,2; req_ready[1] and req_ready[3] never assert.
REQ-030 The bench SHALL cover: fifo_full=1 for 3 cycles while req_valid=4'b0010 -> fifo_wr_en=0 and req_ready=0 for 3 cycles, then producer 1 is written on the first cycle with full=0.
REQ-031 The bench SHALL cover: FIFO_ARB_BURST_EN with BURST_LEN=4 and req_valid=4'b1111 -> grants 0,0,0,0,1,1,1,1,2 ...
REQ-032 The bench SHALL cover: FIFO_ARB_BURST_EN with producer 0 dropping valid after 2 beats -> the next grant goes to producer 1 on the cycle of the drop.
REQ-033 The bench SHALL cover: rst asserted during a burst at beat 2 -> no write in the reset cycle, and the first grant after reset goes to producer 0 with burst_cnt restarting.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the grant for up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_params
    $error("fifo_wr_arbiter: NUM_REQ or BURST_LEN out of range");
  end

  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [GW-1:0] winner;
  logic          hold_lock;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  logic          lock_q, lock_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  // The locked requester keeps the grant only while it still presents a beat.
  assign hold_lock = lock_q && req_valid[last_grant_q];
`else
  assign hold_lock = 1'b0;
`endif

  // rst gates the strobe directly so the reset cycle itself never writes.
  assign fifo_wr_en = (|req_valid) && !fifo_full && !rst;

  // Walk the offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner = last_grant_q;
    if (!hold_lock) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (req_valid[GW'((int'(last_grant_q) + k) % NUM_REQ)]) begin
          winner = GW'((int'(last_grant_q) + k) % NUM_REQ);
        end
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    grant_id  = '0;
    if (fifo_wr_en) begin
      grant_id = winner;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner == GW'(i)) begin
          req_ready[i] = 1'b1;
          fifo_din     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
`ifdef FIFO_ARB_BURST_EN
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
`endif
    if (fifo_wr_en) begin
      last_grant_d = winner;
`ifdef FIFO_ARB_BURST_EN
      if (hold_lock) begin
        if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
          lock_d      = 1'b0;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end else if (BURST_LEN > 1) begin
        lock_d      = 1'b1;
        burst_cnt_d = CW'(1);
      end else begin
        lock_d      = 1'b0;
        burst_cnt_d = '0;
      end
    end else if (!fifo_full && lock_q && !req_valid[last_grant_q]) begin
      // Locked requester went idle without a full stall: give up the burst.
      lock_d      = 1'b0;
      burst_cnt_d = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; reset is synchronous, so rst is only seen on a clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      lock_q       <= 1'b0;
      burst_cnt_q  <= '0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
`ifdef FIFO_ARB_BURST_EN
      lock_q       <= lock_d;
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a grant/beats-left reference model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int GW = 2;
`ifdef FIFO_ARB_BURST_EN
  localparam int MB = BL;
`else
  localparam int MB = 1;
`endif

  localparam logic [NR*DW-1:0] FIXED_DATA = 32'h4433_2211;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = FIXED_DATA;
  logic             fifo_full = 1'b0;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_din;
  logic [GW-1:0]    grant_id;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic          full;
    logic          wr;
    int            gid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [NR-1:0] val, input logic f,
                              input logic wr, input int gid);
    vec_t v;
    v.rst   = r;
    v.valid = val;
    v.full  = f;
    v.wr    = wr;
    v.gid   = gid;
    return v;
  endfunction

  function automatic bit vbit(input logic [NR-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Apply inputs half a period before the rising edge, sample outputs 1 ns later.
  task automatic drive(input logic r, input logic [NR-1:0] val, input logic f);
    @(negedge clk);
    rst       = r;
    req_valid = val;
    fifo_full = f;
    #1;
  endtask

  // Expected outputs with the fixed data pattern: producer g carries 0x11*(g+1).
  task automatic expect_out(input string tag, input logic wr, input int gid);
    logic [NR-1:0] e_ready;
    logic [DW-1:0] e_din;
    e_ready = wr ? NR'(1 << gid) : '0;
    e_din   = wr ? DW'(8'h11 * (gid + 1)) : '0;
    check({tag, ".wr_en"},    32'(fifo_wr_en), 32'(wr));
    check({tag, ".ready"},    32'(req_ready),  32'(e_ready));
    check({tag, ".grant_id"}, 32'(grant_id),   wr ? 32'(gid) : 32'd0);
    check({tag, ".din"},      32'(fifo_din),   32'(e_din));
  endtask

`ifdef FIFO_ARB_BURST_EN
  localparam int R32_B2   = 0;
  localparam int R32_DROP = 1;
  int r33_exp[5] = '{0, 0, 0, 0, 1};
`else
  localparam int R32_B2   = 1;
  localparam int R32_DROP = 2;
  int r33_exp[5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    int            m_last;
    int            m_left;
    int            w;
    logic [NR-1:0] e_ready;
    logic          e_wr;
    logic [DW-1:0] e_din;
    int            e_gid;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(1, 4'b1111, 0, 0, 0));
`ifdef FIFO_ARB_BURST_EN
    foreach (r33_exp[i]) begin end
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 4'b1111, 0, 1, i / 4));
    vecs.push_back(mk(1, 4'b0101, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 4'b0101, 0, 1, (i < 4) ? 0 : 2));
    vecs.push_back(mk(0, 4'b0101, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 1));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 4'b1010, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 0, 1, 3));
`else
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 4'b1111, 0, 1, i % 4));
    vecs.push_back(mk(1, 4'b0101, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'b0101, 0, 1, (i % 2) * 2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 1));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 4'b1010, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'b1010, 0, 1, (i % 2 == 0) ? 3 : 1));
`endif
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0));

    req_data = FIXED_DATA;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].full);
      expect_out($sformatf("vec%0d", i), vecs[i].wr, vecs[i].gid);
    end

    // ---------------- owner drops valid mid-burst ----------------
    drive(1, 4'b1111, 0);
    expect_out("drop.rst", 0, 0);
    drive(0, 4'b1111, 0);
    expect_out("drop.b1", 1, 0);
    drive(0, 4'b1111, 0);
    expect_out("drop.b2", 1, R32_B2);
    drive(0, 4'b1110, 0);
    expect_out("drop.next", 1, R32_DROP);

    // ---------------- reset in the middle of a burst ----------------
    drive(1, 4'b1111, 0);
    drive(0, 4'b1111, 0);
    expect_out("rstmid.b1", 1, 0);
    drive(0, 4'b1111, 0);
    expect_out("rstmid.b2", 1, R32_B2);
    drive(1, 4'b1111, 0);
    expect_out("rstmid.rst", 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b1111, 0);
      expect_out($sformatf("rstmid.after%0d", i), 1, r33_exp[i]);
    end

    // ---------------- random traffic vs reference model ----------------
    // Model state: last granted producer and beats still owed to it in this burst.
    m_last = NR - 1;
    m_left = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst       = (c == 0) || ($urandom_range(0, 49) == 0);
      req_valid = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      #1;

      e_wr    = 1'b0;
      e_gid   = 0;
      e_ready = '0;
      e_din   = '0;
      if (rst) begin
        m_last = NR - 1;
        m_left = 0;
      end else if (!fifo_full) begin
        if (m_left > 0 && !vbit(req_valid, m_last)) m_left = 0;
        if (req_valid != '0) begin
          if (m_left > 0) begin
            w      = m_last;
            m_left = m_left - 1;
          end else begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
              if (w < 0 && vbit(req_valid, (m_last + k) % NR)) w = (m_last + k) % NR;
            end
            m_left = MB - 1;
          end
          m_last  = w;
          e_wr    = 1'b1;
          e_gid   = w;
          e_ready = NR'(1 << w);
          e_din   = DW'(req_data >> (w * DW));
        end
      end

      check($sformatf("rnd%0d.wr_en", c),    32'(fifo_wr_en), 32'(e_wr));
      check($sformatf("rnd%0d.ready", c),    32'(req_ready),  32'(e_ready));
      check($sformatf("rnd%0d.grant_id", c), 32'(grant_id),   32'(e_gid));
      check($sformatf("rnd%0d.din", c),      32'(fifo_din),   32'(e_din));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
